// File: rtl/oh_memory_bist.sv
// oh_memory_bist: March C- self-test controller driving a dual-port memory wrapper.
// Ports: clk/nreset (async active-low), start pulse; bist_en/we/wem/addr/din write side;
// bist_rd_en/bist_rd_addr read side with rd_dout returned one cycle later;
// busy/done/fail status with fail_addr/fail_elem of the first mismatch.
// Macro OH_BIST_DIAG_EN: adds fail_count and runs to completion instead of aborting.
module oh_memory_bist #(
   parameter int DW    = 104,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          start,
   output logic          bist_en,
   output logic          bist_we,
   output logic [DW-1:0] bist_wem,
   output logic [AW-1:0] bist_addr,
   output logic [DW-1:0] bist_din,
   output logic          bist_rd_en,
   output logic [AW-1:0] bist_rd_addr,
   input  logic [DW-1:0] rd_dout,
   output logic          busy,
   output logic          done,
   output logic          fail,
   output logic [AW-1:0] fail_addr,
   output logic [2:0]    fail_elem
`ifdef OH_BIST_DIAG_EN
   ,
   output logic [15:0]   fail_count
`endif
);
`ifdef OH_BIST_DIAG_EN
   localparam bit ABORT = 1'b0;
`else
   localparam bit ABORT = 1'b1;
`endif
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state;
   logic [2:0] elem, chk_e, op_e;
   logic [AW-1:0] addr, chk_a, op_a;
   logic ph, chk_v, two, down, term, fin, stay, run, act, op_p, op_rd, op_we, mism, abort, ld;
   // elem/addr/ph describe the operation currently on the memory pins; op_* is the next one
   always_comb begin
      two   = elem != 3'd0 && elem != 3'd5;
      down  = elem == 3'd3 || elem == 3'd4;
      term  = down ? addr == '0 : addr == LAST;
      fin   = term && elem == 3'd5;
      stay  = two && !ph;
      run   = state == RUN;
      act   = state == RUN || state == DRAIN;
      op_e  = !run ? 3'd0 : (stay || !term) ? elem : elem + 3'd1;
      op_a  = !run ? '0 : stay ? addr : !term ? (down ? addr - AW'(1) : addr + AW'(1)) :
              (elem == 3'd2 || elem == 3'd3) ? LAST : '0;
      op_p  = run && stay;
      op_rd = op_e == 3'd5 || (op_e != 3'd0 && !op_p);
      op_we = !op_rd;
      // r1 elements (2, 4) expect all ones, every other read expects all zeros
      mism  = chk_v && rd_dout != {DW{chk_e == 3'd2 || chk_e == 3'd4}};
      abort = ABORT && mism;
      ld    = (!act && start) || (run && !abort && !fin);
   end
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state        <= IDLE;
         elem         <= '0;
         addr         <= '0;
         ph           <= 1'b0;
         chk_v        <= 1'b0;
         chk_e        <= '0;
         chk_a        <= '0;
         bist_en      <= 1'b0;
         bist_we      <= 1'b0;
         bist_wem     <= '0;
         bist_addr    <= '0;
         bist_din     <= '0;
         bist_rd_en   <= 1'b0;
         bist_rd_addr <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         fail         <= 1'b0;
         fail_addr    <= '0;
         fail_elem    <= '0;
`ifdef OH_BIST_DIAG_EN
         fail_count   <= '0;
`endif
      end else begin
         // read pipeline: rd_dout of this cycle belongs to last cycle's read
         chk_v <= bist_rd_en;
         chk_e <= elem;
         chk_a <= addr;
         if (ld) begin
            elem         <= op_e;
            addr         <= op_a;
            ph           <= op_p;
            bist_we      <= op_we;
            bist_wem     <= {DW{op_we}};
            bist_din     <= {DW{op_we && op_e[0]}};
            bist_addr    <= op_a;
            bist_rd_addr <= op_a;
            bist_rd_en   <= op_rd;
         end else if (act) begin
            bist_we    <= 1'b0;
            bist_wem   <= '0;
            bist_din   <= '0;
            bist_rd_en <= 1'b0;
         end
         if (!act && start) begin
            state     <= RUN;
            bist_en   <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
`ifdef OH_BIST_DIAG_EN
            fail_count <= '0;
`endif
         end else if (act) begin
            if (mism && !fail) begin
               fail      <= 1'b1;
               fail_addr <= chk_a;
               fail_elem <= chk_e;
            end
`ifdef OH_BIST_DIAG_EN
            if (mism && fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
`endif
            if (abort || state == DRAIN) begin
               state   <= DONE;
               bist_en <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b1;
            end else if (fin) state <= DRAIN;
         end
      end
   end
endmodule

// File: tb/tb_oh_memory_bist.sv
// tb_oh_memory_bist: directed bench for oh_memory_bist on an 8-word memory model with stuck-at faults.
module tb_oh_memory_bist;
   localparam int DW = 104;
   localparam int DEPTH = 8;
   localparam int AW = 3;
   logic clk = 1'b0, nreset, start;
   logic bist_en, bist_we, bist_rd_en, busy, done, fail;
   logic [DW-1:0] bist_wem, bist_din, rd_dout;
   logic [AW-1:0] bist_addr, bist_rd_addr, fail_addr;
   logic [2:0] fail_elem;
`ifdef OH_BIST_DIAG_EN
   logic [15:0] fail_count;
`endif
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] f1 [DEPTH];
   logic [DW-1:0] f0 [DEPTH];
   bit we_a [256];
   bit rd_a [256];
   bit en_a [256];
   bit dn_a [256];
   bit fl_a [256];
   int ad_a [256];
   int din_a [256];
   int n_chk = 0, n_fail = 0, dc, bad, err, cnt;
   oh_memory_bist #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .nreset(nreset), .start(start),
      .bist_en(bist_en), .bist_we(bist_we), .bist_wem(bist_wem), .bist_addr(bist_addr),
      .bist_din(bist_din), .bist_rd_en(bist_rd_en), .bist_rd_addr(bist_rd_addr),
      .rd_dout(rd_dout), .busy(busy), .done(done), .fail(fail),
      .fail_addr(fail_addr), .fail_elem(fail_elem)
`ifdef OH_BIST_DIAG_EN
      , .fail_count(fail_count)
`endif
   );
   always #5 clk = ~clk;
   // memory with per-address stuck-at-1 (f1) and stuck-at-0 (f0) masks applied on read
   always @(posedge clk) begin
      if (bist_we) mem[bist_addr] <= (mem[bist_addr] & ~bist_wem) | (bist_din & bist_wem);
      if (bist_rd_en) rd_dout <= (mem[bist_rd_addr] | f1[bist_rd_addr]) & ~f0[bist_rd_addr];
   end
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // called at a negedge; start is sampled at edge 0, cycle c is sampled at the negedge after edge c
   task automatic run(input bit hold, output int d);
      d = -1;
      bad = 0;
      foreach (we_a[i]) begin
         we_a[i] = 0; rd_a[i] = 0; en_a[i] = 0; dn_a[i] = 0; fl_a[i] = 0; ad_a[i] = -1; din_a[i] = -1;
      end
      start = 1'b1;
      for (int c = 1; c < 250; c++) begin
         @(negedge clk);
         start = hold && !done;
         we_a[c] = bist_we; rd_a[c] = bist_rd_en; en_a[c] = bist_en;
         dn_a[c] = done; fl_a[c] = fail; ad_a[c] = int'(bist_addr);
         din_a[c] = bist_din == '0 ? 0 : bist_din == '1 ? 1 : 2;
         if (bist_we && bist_rd_en) bad++;
         if ((bist_we || bist_rd_en) && bist_addr != bist_rd_addr) bad++;
         if (bist_wem != {DW{bist_we}}) bad++;
         if (din_a[c] == 2) bad++;
         if (done && d < 0) d = c;
         if (d > 0 && c >= d + 2) break;
      end
      start = 1'b0;
      if (d < 0) check("done_timeout", 0, 1);
   endtask
   function automatic int e3_err();
      int e = 0;
      for (int i = 0; i < 8; i++) begin
         if (!(rd_a[41+2*i] && !we_a[41+2*i] && ad_a[41+2*i] == 7 - i)) e++;
         if (!(we_a[42+2*i] && ad_a[42+2*i] == 7 - i && din_a[42+2*i] == 1)) e++;
      end
      return e;
   endfunction
   initial begin
      nreset = 1'b0;
      start = 1'b0;
      foreach (mem[i]) begin
         mem[i] = '0; f1[i] = '0; f0[i] = '0;
      end
      #2;
      check("rst_bist_en", bist_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_fail", fail, 0);
      check("rst_we_rd", {bist_we, bist_rd_en}, 0);
      check("rst_fail_info", {fail_addr, fail_elem}, 0);
      @(negedge clk);
      nreset = 1'b1;
      @(negedge clk);
      // clean run
      run(0, dc);
      check("clean_done_cyc", dc, 82);
      check("clean_fail", fail, 0);
      check("clean_en_81", en_a[81], 1);
      check("clean_en_82", en_a[82], 0);
      check("clean_done_81", dn_a[81], 0);
      check("clean_busy_end", busy, 0);
      err = 0;
      for (int c = 1; c <= 8; c++)
         if (!(we_a[c] && !rd_a[c] && ad_a[c] == c - 1 && din_a[c] == 0)) err++;
      check("clean_e0_seq", err, 0);
      check("clean_e3_seq", e3_err(), 0);
      err = 0;
      for (int c = 73; c <= 80; c++) if (!(rd_a[c] && ad_a[c] == c - 73)) err++;
      check("clean_e5_seq", err, 0);
      cnt = 0;
      for (int c = 1; c <= 81; c++) cnt += int'(we_a[c]);
      check("clean_writes", cnt, 40);
      cnt = 0;
      for (int c = 1; c <= 81; c++) cnt += int'(rd_a[c]);
      check("clean_reads", cnt, 40);
      check("clean_pin_rules", bad, 0);
      // start held high through the run
      run(1, dc);
      check("hold_done_cyc", dc, 82);
      check("hold_fail", fail, 0);
      check("hold_e3_seq", e3_err(), 0);
      // bit 3 of address 5 stuck at 1
      f1[5][3] = 1'b1;
      run(0, dc);
      check("sa1_fail", fail, 1);
      check("sa1_elem", fail_elem, 1);
      check("sa1_addr", fail_addr, 5);
`ifdef OH_BIST_DIAG_EN
      check("sa1_done_cyc", dc, 82);
      check("sa1_count", fail_count, 3);
`else
      check("sa1_done_cyc", dc, 21);
      check("sa1_en_off", en_a[21], 0);
      cnt = 0;
      for (int c = 21; c <= 23; c++) cnt += int'(we_a[c] || rd_a[c]);
      check("sa1_no_more_ops", cnt, 0);
`endif
      // fault removed, rerun clears flags on the start edge
      f1[5] = '0;
      run(0, dc);
      check("rerun_fail_c1", fl_a[1], 0);
      check("rerun_done_c1", dn_a[1], 0);
      check("rerun_done_cyc", dc, 82);
      check("rerun_fail", fail, 0);
`ifdef OH_BIST_DIAG_EN
      check("rerun_count", fail_count, 0);
`endif
      // bit 0 of address 0 stuck at 0
      f0[0][0] = 1'b1;
      run(0, dc);
      check("sa0_fail", fail, 1);
      check("sa0_elem", fail_elem, 2);
      check("sa0_addr", fail_addr, 0);
`ifdef OH_BIST_DIAG_EN
      check("sa0_done_cyc", dc, 82);
      check("sa0_count", fail_count, 2);
`else
      check("sa0_done_cyc", dc, 27);
`endif
      f0[0] = '0;
      // asynchronous reset in the middle of e2
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      check("mid_busy_before", busy, 1);
      #2 nreset = 1'b0;
      #1;
      check("arst_en_we_rd", {bist_en, bist_we, bist_rd_en}, 0);
      check("arst_flags", {busy, done, fail}, 0);
      check("arst_addr", {bist_addr, bist_rd_addr}, 0);
      @(negedge clk);
      nreset = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_idle", {busy, bist_en, done}, 0);
      run(0, dc);
      check("post_rst_done_cyc", dc, 82);
      check("post_rst_fail", fail, 0);
      check("post_rst_e3_seq", e3_err(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/oh_memory_bist.md
Name: oh_memory_bist

Overview:
- Single-clock March C- built-in self-test controller that sits directly upstream of the dual-port memory wrapper.
- Drives the memory BIST write interface (bist_en/we/wem/addr/din) and the memory read port, and compares rd_dout against expected data.
- Reports pass/fail to an always-on test/config block.
- Instantiated once per memory, clocked by the same clock as both memory ports.

Parameters:
DW, 104, memory data width
DEPTH, 32, memory depth in words (>=2)
AW, $clog2(DEPTH), address width

Ports:
clk  input  1  clock (memory wr_clk and rd_clk tied to it)
nreset  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse, begins test when not busy
bist_en  output  1  memory BIST mux select, high while test runs
bist_we  output  1  BIST write enable
bist_wem  output  DW  per-bit write mask, all ones whenever bist_we=1, else 0
bist_addr  output  AW  BIST write address
bist_din  output  DW  BIST write data (all zeros or all ones)
bist_rd_en  output  1  memory read enable
bist_rd_addr  output  AW  memory read address
rd_dout  input  DW  memory read data, valid one cycle after bist_rd_en
busy  output  1  test in progress (RUN or DRAIN)
done  output  1  test finished, held until next start
fail  output  1  mismatch detected, held until next start
fail_addr  output  AW  address of first mismatch
fail_elem  output  3  March element index (0-5) of first mismatch

Behaviour:
- Reset: all outputs 0; state IDLE.
- All memory-side outputs are registered.
- States: IDLE -> RUN (start=1) -> DRAIN -> DONE. DONE -> RUN on start; done/fail/fail_addr/fail_elem clear on that edge. start is ignored while busy.
- Elements (W0 = all zeros, W1 = all ones):
  - e0: up w0
  - e1: up (r0, w1)
  - e2: up (r1, w0)
  - e3: down (r0, w1)
  - e4: down (r1, w0)
  - e5: up r0
- "up" = address 0..DEPTH-1; "down" = DEPTH-1..0.
- Each single-op element takes 1 cycle per address. Each r,w element takes 2 cycles per address: the read cycle (bist_rd_en=1), then the write cycle (bist_we=1), both at the same address.
- Only one of bist_rd_en and bist_we is ever high in a cycle. bist_addr and bist_rd_addr both carry the current address.
- Compare: expected value and element index are registered alongside bist_rd_en. rd_dout is compared in the following cycle; a mismatch is any differing bit.
- Timing: start sampled at edge 0. RUN occupies cycles 1..10*DEPTH. DRAIN lasts one cycle (final compare). done=1 and busy=0 from cycle 10*DEPTH+2.
- On first mismatch: fail=1; fail_addr and fail_elem latched.
- Without diagnostic mode, a mismatch aborts immediately: next cycle state=DONE, bist_en/bist_we/bist_rd_en=0, done=1.
- bist_en=1 only in RUN and DRAIN; bist_we and bist_rd_en are 0 in DRAIN.
- Address wrap: element transition on the terminal address (DEPTH-1 for up, 0 for down). No wrap-around within an element.
- Async reset mid-test: immediate return to IDLE with all outputs 0. The memory is not restored.

Optional Feature:
- Macro OH_BIST_DIAG_EN.
- Defined:
  - Adds output fail_count (16 bits, saturating at 0xFFFF, reset 0, cleared on start).
  - Counts every mismatching read.
  - The test runs to completion instead of aborting.
  - fail_addr/fail_elem still hold the first mismatch.
- Undefined: no fail_count port; abort on first mismatch as described above.

Test Plan:
- DEPTH=8, ideal memory model, start pulse → address sequence e0 0..7, e3 7..0; done rises at cycle 82; fail=0; bist_en falls at cycle 82.
- DEPTH=8, bit 3 of addr 5 stuck-at-1, diag undefined → fail=1, fail_elem=1, fail_addr=5; done asserted the cycle after the compare; no further writes issued.
- Same fault with OH_BIST_DIAG_EN → run completes at cycle 82; fail_count=3 (e1, e3, e5 r0 reads); fail_elem=1, fail_addr=5.
- start pulsed every cycle during RUN → ignored; timing identical to the single-start case; second start after done → flags cleared, test reruns.
- nreset asserted mid-e2 → all outputs 0 asynchronously; after release, state IDLE; next start runs a full clean test.
- Bit 0 of addr 0 stuck-at-0, diag undefined → fail_elem=2, fail_addr=0 (first r1 read).
